// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences every instruction class and drives all datapath strobes.
// Optional interrupt support (INT/ERET states, in_isr flag, irq_ack) is enabled by defining CTRL_IRQ_EN.
module multicycle_ctrl #(
    parameter logic [5:0]  OP_IN      = 6'b011100,
    parameter logic [5:0]  OP_OUT     = 6'b011101,
    parameter logic [5:0]  OP_ERET    = 6'b010000,
    parameter int unsigned IN_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       irq,
    output logic       irq_ack,
    input  logic       uart_valid,
    output logic       uart_ack,
    output logic       leds_we,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] wreg_dst,
    output logic [1:0] wreg_data_sel,
    output logic [2:0] pc_source,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       alu_src_a,
    output logic       imm_com,
    output logic       int_save_pc,
    output logic       load_uart
);

    localparam int unsigned CNT_W = (IN_TIMEOUT > 1) ? $clog2(IN_TIMEOUT) : 1;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL,
        S_IN_WAIT, S_IN_WB, S_OUT, S_ERET, S_INT, S_END
    } state_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] wreg_dst;
        logic [1:0] wreg_data_sel;
        logic [2:0] pc_source;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic       imm_com;
        logic       int_save_pc;
        logic       load_uart;
        logic       irq_ack;
        logic       leds_we;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           term_next_c;

`ifdef CTRL_IRQ_EN
    logic in_isr_q, in_isr_d;

    // Interrupts are only taken on an instruction boundary and never nest.
    assign term_next_c = (irq && !in_isr_q) ? S_INT : S_FETCH;
`else
    logic unused_irq;

    assign unused_irq  = irq;
    assign term_next_c = S_FETCH;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ctrl_d  = '0;
`ifdef CTRL_IRQ_EN
        in_isr_d = in_isr_q;
`endif
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_RTYPE:        state_d = S_R_EXEC;
                    OPC_LW, OPC_SW:   state_d = S_MEM_ADDR;
                    OPC_BEQ:          state_d = S_BRANCH;
                    OPC_J:            state_d = S_JUMP;
                    OPC_JAL:          state_d = S_JAL;
                    OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SLTI:
                                      state_d = S_I_EXEC;
                    OP_IN:            state_d = S_IN_WAIT;
                    OP_OUT:           state_d = S_OUT;
`ifdef CTRL_IRQ_EN
                    OP_ERET:          state_d = S_ERET;
`else
                    OP_ERET:          state_d = S_END;
`endif
                    default:          state_d = S_END;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_IN_WAIT: begin
                // Counter only advances when a timeout is configured; it clears on every exit.
                if (uart_valid) begin
                    state_d = S_IN_WB;
                end else if ((IN_TIMEOUT != 0) && (cnt_q == CNT_W'(IN_TIMEOUT - 1))) begin
                    state_d = S_END;
                end else if (IN_TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef CTRL_IRQ_EN
            S_INT: begin
                in_isr_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_ERET: begin
                in_isr_d = 1'b0;
                state_d  = term_next_c;
            end
`endif
            default:    state_d = term_next_c;
        endcase

        // Strobes are decoded from the next state and registered, so they line up with state_q.
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
            end
            S_DECODE:   ctrl_d.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.wreg_data_sel = 2'b01;
            end
            S_MEM_WR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            S_R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.wreg_dst  = 2'b01;
            end
            S_I_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = 2'b10;
                ctrl_d.imm_com   = 1'b1;
            end
            S_I_WB:     ctrl_d.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 3'd1;
            end
            S_JUMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 3'd2;
            end
            S_JAL: begin
                ctrl_d.pc_write      = 1'b1;
                ctrl_d.pc_source     = 3'd2;
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.wreg_dst      = 2'b10;
                ctrl_d.wreg_data_sel = 2'b10;
            end
            S_IN_WAIT:  ctrl_d.load_uart = 1'b1;
            S_IN_WB: begin
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.wreg_data_sel = 2'b01;
            end
            S_OUT:      ctrl_d.leds_we = 1'b1;
`ifdef CTRL_IRQ_EN
            S_ERET: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 3'd4;
            end
            S_INT: begin
                ctrl_d.int_save_pc = 1'b1;
                ctrl_d.pc_write    = 1'b1;
                ctrl_d.pc_source   = 3'd3;
                ctrl_d.irq_ack     = 1'b1;
            end
`endif
            default:    ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            cnt_q   <= '0;
`ifdef CTRL_IRQ_EN
            in_isr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
`ifdef CTRL_IRQ_EN
            in_isr_q <= in_isr_d;
`endif
        end
    end

    // Byte is consumed in the same cycle the datapath captures it.
    assign uart_ack      = uart_valid && (state_q == S_IN_WAIT);

    assign alu_op        = ctrl_q.alu_op;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign wreg_dst      = ctrl_q.wreg_dst;
    assign wreg_data_sel = ctrl_q.wreg_data_sel;
    assign pc_source     = ctrl_q.pc_source;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign i_or_d        = ctrl_q.i_or_d;
    assign reg_write     = ctrl_q.reg_write;
    assign ir_write      = ctrl_q.ir_write;
    assign pc_write      = ctrl_q.pc_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign imm_com       = ctrl_q.imm_com;
    assign int_save_pc   = ctrl_q.int_save_pc;
    assign load_uart     = ctrl_q.load_uart;
    assign irq_ack       = ctrl_q.irq_ack;
    assign leds_we       = ctrl_q.leds_we;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected strobe bundles are queued as stimulus is driven and popped at each negedge.
// Two instances: default (no IN timeout) and IN_TIMEOUT=8 for the timeout sequence.
module tb_multicycle_ctrl;

    typedef enum logic [4:0] {
        S_IDLE, S_F, S_D, S_MA, S_MRD, S_MWB, S_MWR, S_REX, S_RWB, S_IEX, S_IWB,
        S_BR, S_J, S_JAL, S_INW, S_INWB, S_OUT, S_ERET, S_INT, S_END, S_NA
    } st_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] wreg_dst;
        logic [1:0] wreg_data_sel;
        logic [2:0] pc_source;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic       imm_com;
        logic       int_save_pc;
        logic       load_uart;
        logic       irq_ack;
        logic       leds_we;
        logic       uart_ack;
    } ctl_t;

    typedef struct packed {
        logic [5:0]      op;
        logic            uv;
        logic [5:0][4:0] seq;
    } vec_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_IN = 6'b011100, OP_OUT = 6'b011101, OP_ERET = 6'b010000;
    localparam logic [5:0] OP_NOP = 6'b111111;

    logic clk, rst, irq, uart_valid;
    logic [5:0] opcode;

    logic       irq_ack, uart_ack, leds_we, mem_read, mem_write, i_or_d, reg_write, ir_write;
    logic       pc_write, pc_write_cond, alu_src_a, imm_com, int_save_pc, load_uart;
    logic [1:0] alu_op, alu_src_b, wreg_dst, wreg_data_sel;
    logic [2:0] pc_source;

    logic       irq_ack_t, uart_ack_t, leds_we_t, mem_read_t, mem_write_t, i_or_d_t, reg_write_t, ir_write_t;
    logic       pc_write_t, pc_write_cond_t, alu_src_a_t, imm_com_t, int_save_pc_t, load_uart_t;
    logic [1:0] alu_op_t, alu_src_b_t, wreg_dst_t, wreg_data_sel_t;
    logic [2:0] pc_source_t;

    ctl_t obs, obs_t;
    ctl_t sbq[$];
    vec_t tbl[$];
    int   n_chk, n_fail;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .irq(irq), .irq_ack(irq_ack),
        .uart_valid(uart_valid), .uart_ack(uart_ack), .leds_we(leds_we),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .wreg_dst(wreg_dst), .wreg_data_sel(wreg_data_sel),
        .pc_source(pc_source), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_src_a(alu_src_a), .imm_com(imm_com), .int_save_pc(int_save_pc), .load_uart(load_uart)
    );

    multicycle_ctrl #(.IN_TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst), .opcode(opcode), .irq(irq), .irq_ack(irq_ack_t),
        .uart_valid(uart_valid), .uart_ack(uart_ack_t), .leds_we(leds_we_t),
        .alu_op(alu_op_t), .alu_src_b(alu_src_b_t), .wreg_dst(wreg_dst_t), .wreg_data_sel(wreg_data_sel_t),
        .pc_source(pc_source_t), .mem_read(mem_read_t), .mem_write(mem_write_t), .i_or_d(i_or_d_t),
        .reg_write(reg_write_t), .ir_write(ir_write_t), .pc_write(pc_write_t), .pc_write_cond(pc_write_cond_t),
        .alu_src_a(alu_src_a_t), .imm_com(imm_com_t), .int_save_pc(int_save_pc_t), .load_uart(load_uart_t)
    );

    assign obs = '{alu_op, alu_src_b, wreg_dst, wreg_data_sel, pc_source, mem_read, mem_write, i_or_d,
                   reg_write, ir_write, pc_write, pc_write_cond, alu_src_a, imm_com, int_save_pc,
                   load_uart, irq_ack, leds_we, uart_ack};
    assign obs_t = '{alu_op_t, alu_src_b_t, wreg_dst_t, wreg_data_sel_t, pc_source_t, mem_read_t, mem_write_t,
                     i_or_d_t, reg_write_t, ir_write_t, pc_write_t, pc_write_cond_t, alu_src_a_t, imm_com_t,
                     int_save_pc_t, load_uart_t, irq_ack_t, leds_we_t, uart_ack_t};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference strobe set for each control state.
    function automatic ctl_t exp_of(input st_e s);
        ctl_t e;
        e = '0;
        case (s)
            S_F:    begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; end
            S_D:    e.alu_src_b = 2'b11;
            S_MA:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MRD:  begin e.mem_read = 1; e.i_or_d = 1; end
            S_MWB:  begin e.reg_write = 1; e.wreg_data_sel = 2'b01; end
            S_MWR:  begin e.mem_write = 1; e.i_or_d = 1; end
            S_REX:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            S_RWB:  begin e.reg_write = 1; e.wreg_dst = 2'b01; end
            S_IEX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; e.imm_com = 1; end
            S_IWB:  e.reg_write = 1;
            S_BR:   begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 3'd1; end
            S_J:    begin e.pc_write = 1; e.pc_source = 3'd2; end
            S_JAL:  begin e.pc_write = 1; e.pc_source = 3'd2; e.reg_write = 1;
                          e.wreg_dst = 2'b10; e.wreg_data_sel = 2'b10; end
            S_INW:  e.load_uart = 1;
            S_INWB: begin e.reg_write = 1; e.wreg_data_sel = 2'b01; end
            S_OUT:  e.leds_we = 1;
            S_ERET: begin e.pc_write = 1; e.pc_source = 3'd4; end
            S_INT:  begin e.int_save_pc = 1; e.pc_write = 1; e.pc_source = 3'd3; e.irq_ack = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string nm, input ctl_t got);
        ctl_t e;
        e = sbq.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, e);
        end
    endtask

    // One clock of stimulus; the expected bundle is queued before the edge and checked at the negedge.
    task automatic step(input st_e s, input logic [5:0] op, input logic uv, input logic use_to);
        ctl_t e;
        e = exp_of(s);
        e.uart_ack = (s == S_INW) && uv;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        opcode     = op;
        uart_valid = uv;
        @(negedge clk);
        check(s.name(), use_to ? obs_t : obs);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        uart_valid = 1'b0;
        irq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sbq.push_back('0);
        check("in_reset", obs);
        rst = 1'b1;
        #1;
        sbq.push_back('0);
        check("idle", obs);
        sbq.push_back('0);
        check("idle_to", obs_t);
    endtask

    function automatic void add_vec(input logic [5:0] op, input logic uv, input st_e s0, input st_e s1,
                                    input st_e s2, input st_e s3 = S_NA, input st_e s4 = S_NA,
                                    input st_e s5 = S_NA);
        vec_t v;
        v.op = op;
        v.uv = uv;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
        v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
        tbl.push_back(v);
    endfunction

    initial begin
        st_e s;
        n_chk = 0;
        n_fail = 0;
        opcode = OP_NOP;

        add_vec(OP_R,    1'b0, S_F, S_D, S_REX, S_RWB);
        add_vec(OP_LW,   1'b0, S_F, S_D, S_MA, S_MRD, S_MWB);
        add_vec(OP_SW,   1'b0, S_F, S_D, S_MA, S_MWR);
        add_vec(OP_BEQ,  1'b0, S_F, S_D, S_BR);
        add_vec(OP_J,    1'b0, S_F, S_D, S_J);
        add_vec(OP_JAL,  1'b0, S_F, S_D, S_JAL);
        add_vec(OP_ADDI, 1'b0, S_F, S_D, S_IEX, S_IWB);
        add_vec(OP_ANDI, 1'b1, S_F, S_D, S_IEX, S_IWB);
        add_vec(OP_ORI,  1'b0, S_F, S_D, S_IEX, S_IWB);
        add_vec(OP_XORI, 1'b0, S_F, S_D, S_IEX, S_IWB);
        add_vec(OP_SLTI, 1'b0, S_F, S_D, S_IEX, S_IWB);
        add_vec(OP_OUT,  1'b0, S_F, S_D, S_OUT);
        add_vec(OP_IN,   1'b1, S_F, S_D, S_INW, S_INWB);
        add_vec(OP_NOP,  1'b0, S_F, S_D, S_END);
        add_vec(OP_R,    1'b1, S_F, S_D, S_REX, S_RWB);
`ifdef CTRL_IRQ_EN
        add_vec(OP_ERET, 1'b0, S_F, S_D, S_ERET);
`else
        add_vec(OP_ERET, 1'b0, S_F, S_D, S_END);
`endif

        do_reset();

        foreach (tbl[i]) begin
            for (int k = 0; k < 6; k++) begin
                s = st_e'(tbl[i].seq[k]);
                if (s == S_NA) break;
                step(s, tbl[i].op, tbl[i].uv, 1'b0);
            end
        end

        // IN with a late byte: 10 idle wait cycles, byte arrives in the 11th.
        step(S_F, OP_IN, 1'b0, 1'b0);
        step(S_D, OP_IN, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(S_INW, OP_IN, 1'b0, 1'b0);
        step(S_INW, OP_IN, 1'b1, 1'b0);
        step(S_INWB, OP_IN, 1'b0, 1'b0);

        // Interrupt entry, blocking while in the handler, and return.
        irq = 1'b1;
`ifdef CTRL_IRQ_EN
        step(S_F, OP_ADDI, 1'b0, 1'b0); step(S_D, OP_ADDI, 1'b0, 1'b0);
        step(S_IEX, OP_ADDI, 1'b0, 1'b0); step(S_IWB, OP_ADDI, 1'b0, 1'b0);
        step(S_INT, OP_ADDI, 1'b0, 1'b0);
        step(S_F, OP_OUT, 1'b0, 1'b0); step(S_D, OP_OUT, 1'b0, 1'b0); step(S_OUT, OP_OUT, 1'b0, 1'b0);
        step(S_F, OP_ERET, 1'b0, 1'b0); step(S_D, OP_ERET, 1'b0, 1'b0); step(S_ERET, OP_ERET, 1'b0, 1'b0);
        step(S_F, OP_R, 1'b0, 1'b0); step(S_D, OP_R, 1'b0, 1'b0);
        step(S_REX, OP_R, 1'b0, 1'b0); step(S_RWB, OP_R, 1'b0, 1'b0);
        step(S_INT, OP_R, 1'b0, 1'b0);
        irq = 1'b0;
        step(S_F, OP_ERET, 1'b0, 1'b0); step(S_D, OP_ERET, 1'b0, 1'b0); step(S_ERET, OP_ERET, 1'b0, 1'b0);
`else
        step(S_F, OP_ADDI, 1'b0, 1'b0); step(S_D, OP_ADDI, 1'b0, 1'b0);
        step(S_IEX, OP_ADDI, 1'b0, 1'b0); step(S_IWB, OP_ADDI, 1'b0, 1'b0);
        step(S_F, OP_ERET, 1'b0, 1'b0); step(S_D, OP_ERET, 1'b0, 1'b0); step(S_END, OP_ERET, 1'b0, 1'b0);
        irq = 1'b0;
`endif

        // Asynchronous reset in the middle of a load aborts it at once.
        step(S_F, OP_LW, 1'b0, 1'b0); step(S_D, OP_LW, 1'b0, 1'b0);
        step(S_MA, OP_LW, 1'b0, 1'b0); step(S_MRD, OP_LW, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        sbq.push_back('0);
        check("async_rst", obs);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sbq.push_back('0);
        check("rst_hold", obs);
        rst = 1'b1;
        #1;
        sbq.push_back('0);
        check("idle_after_abort", obs);
        step(S_F, OP_R, 1'b0, 1'b0);

        // IN timeout on the IN_TIMEOUT=8 instance.
        do_reset();
        step(S_F, OP_IN, 1'b0, 1'b1);
        step(S_D, OP_IN, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(S_INW, OP_IN, 1'b0, 1'b1);
        step(S_END, OP_IN, 1'b0, 1'b1);
        step(S_F, OP_NOP, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
